// File: rtl/lsu_ctrl.sv
// Load/store unit sequencer: one req/gnt/rvalid bus transaction per memory op, lane steering and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into address/size faults.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_nbyte,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] NB_WORD = 2'b00;
  localparam logic [1:0] NB_BYTE = 2'b01;
  localparam logic [1:0] NB_HALF = 2'b10;
  localparam logic [1:0] NB_ILL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cause_nxt;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              op_accept;
  logic              op_fault;

  logic              load_p1;
  logic              unsigned_p1;
  logic [1:0]        nbyte_p1;
  logic [1:0]        lo_p1;

  function automatic logic [3:0] byte_en(input logic [1:0] nb, input logic [1:0] lo);
    case (nb)
      NB_BYTE: byte_en = 4'b0001 << lo;
      NB_HALF: byte_en = 4'b0011 << {lo[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] nb, input logic [DATA_W-1:0] wd);
    case (nb)
      NB_BYTE: lane_wdata = {4{wd[7:0]}};
      NB_HALF: lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  // Signed lane temporaries give sign extension on assignment; unsigned loads pad with zeros.
  function automatic logic [DATA_W-1:0] load_extend(input logic [1:0] nb, input logic [1:0] lo,
                                                    input logic uns, input logic [DATA_W-1:0] rd);
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] r;
    b = 8'(rd >> {lo, 3'b000});
    h = 16'(rd >> {lo[1], 4'b0000});
    case (nb)
      NB_BYTE: if (uns) r = {24'd0, b}; else r = b;
      NB_HALF: if (uns) r = {16'd0, h}; else r = h;
      default: r = rd;
    endcase
    load_extend = r;
  endfunction

  always_comb begin
    op_accept = ex_valid & (ex_mem_read | ex_mem_write);
    op_fault  = (ex_mem_read & ex_mem_write) | (ex_nbyte == NB_ILL);
`ifdef LSU_MISALIGN_TRAP_EN
    op_fault  = op_fault | ((ex_nbyte == NB_HALF) & ex_addr[0])
                         | ((ex_nbyte == NB_WORD) & (|ex_addr[1:0]));
`endif
    tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state and completion cause; a response wins over a same-cycle timeout
  always_comb begin
    state_nxt = state;
    cause_nxt = 2'b00;
    case (state)
      S_IDLE: if (op_accept) begin
        if (op_fault) begin
          state_nxt = S_RESP;
          cause_nxt = 2'b01;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: if (tmo_hit) begin
        state_nxt = S_RESP;
        cause_nxt = 2'b11;
      end else if (dmem_gnt) begin
        state_nxt = S_WAIT;
      end
      S_WAIT: if (dmem_rvalid) begin
        state_nxt = S_RESP;
        cause_nxt = dmem_err ? 2'b10 : 2'b00;
      end else if (tmo_hit) begin
        state_nxt = S_RESP;
        cause_nxt = 2'b11;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: combinational outputs; reset forces the stall low even with an op pending
  always_comb begin
    lsu_stall = rst_n & (((state == S_IDLE) & op_accept) | (state == S_REQ) | (state == S_WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state == S_IDLE) && (state_nxt == S_REQ)) begin
      tmo_cnt <= '0;
    end else if ((state == S_REQ) || (state == S_WAIT)) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Stage p1: op attributes latched at acceptance, used when the response returns
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && op_accept) begin
      load_p1     <= ex_mem_read;
      unsigned_p1 <= ex_unsigned;
      nbyte_p1    <= ex_nbyte;
      lo_p1       <= ex_addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      lsu_done      <= 1'b0;
      lsu_err       <= 1'b0;
      lsu_err_cause <= 2'b00;
      lsu_rdata     <= '0;
    end else begin
      dmem_req <= (state_nxt == S_REQ);
      lsu_done <= (state_nxt == S_RESP);
      if ((state == S_IDLE) && op_accept) begin
        dmem_we    <= ex_mem_write;
        dmem_addr  <= {ex_addr[31:2], 2'b00};
        dmem_be    <= byte_en(ex_nbyte, ex_addr[1:0]);
        dmem_wdata <= lane_wdata(ex_nbyte, ex_wdata);
      end
      if (state_nxt == S_RESP) begin
        lsu_err       <= (cause_nxt != 2'b00);
        lsu_err_cause <= cause_nxt;
        lsu_rdata     <= ((state == S_WAIT) && dmem_rvalid && load_p1 && !dmem_err)
                         ? load_extend(nbyte_p1, lo_p1, unsigned_p1, dmem_rdata) : '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, faults, bus error, timeout and asynchronous reset.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned;
  logic [1:0]  ex_nbyte;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_stall, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_err_cause;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int npass = 0;
  int ntotal = 0;

  lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_nbyte(ex_nbyte), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .lsu_err_cause(lsu_err_cause),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [1:0] nb, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_nbyte = nb; ex_unsigned = uns; ex_addr = addr; ex_wdata = wd;
  endtask

  task automatic drop_op();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  // Immediate grant, response on the following cycle.
  task automatic xact(input string tag, input logic rd, input logic wr, input logic [1:0] nb,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdat, input logic rerr,
                      input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                      input logic [31:0] e_rdata, input logic [1:0] e_cause);
    @(negedge clk);
    drive_op(rd, wr, nb, uns, addr, wd);
    #1 chk({tag, ".stall_accept"}, 32'(lsu_stall), 32'd1);
    @(negedge clk);
    chk({tag, ".req"}, 32'(dmem_req), 32'd1);
    chk({tag, ".addr"}, dmem_addr, e_addr);
    chk({tag, ".be"}, 32'(dmem_be), 32'(e_be));
    chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
    if (wr) chk({tag, ".wdata"}, dmem_wdata, e_wd);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
    chk({tag, ".done_early"}, 32'(lsu_done), 32'd0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdat; dmem_err = rerr;
    @(negedge clk);
    chk({tag, ".done"}, 32'(lsu_done), 32'd1);
    chk({tag, ".rdata"}, lsu_rdata, e_rdata);
    chk({tag, ".err"}, 32'(lsu_err), 32'(e_cause != 2'b00));
    chk({tag, ".cause"}, 32'(lsu_err_cause), 32'(e_cause));
    chk({tag, ".stall_resp"}, 32'(lsu_stall), 32'd0);
    drop_op();
    dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(lsu_done), 32'd0);
    chk({tag, ".rdata_hold"}, lsu_rdata, e_rdata);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_unsigned = 1'b0;
    ex_nbyte = 2'b00; ex_addr = '0; ex_wdata = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;

    @(negedge clk);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.done", 32'(lsu_done), 32'd0);
    chk("rst.stall", 32'(lsu_stall), 32'd0);
    chk("rst.rdata", lsu_rdata, 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    rst_n = 1'b1;

    // lb 0x1003: top byte 0x80 sign-extended
    xact("lb", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 1'b0,
         32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'b00);
    // lhu 0x2002: upper half zero-extended
    xact("lhu", 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1'b0,
         32'h0000_2000, 4'b1100, 32'h0, 32'h0000_BEEF, 2'b00);
    // lh 0x2000: lower half 0x8001 sign-extended
    xact("lh", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_8001, 1'b0,
         32'h0000_2000, 4'b0011, 32'h0, 32'hFFFF_8001, 2'b00);
    // sh 0x5002: half replicated into both lanes
    xact("sh", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_5002, 32'hAAAA_8001, 32'h0, 1'b0,
         32'h0000_5000, 4'b1100, 32'h8001_8001, 32'h0, 2'b00);
    // lbu with bus error: cause 10, data forced to 0
    xact("buserr", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_6001, 32'h0, 32'hFFFF_FFFF, 1'b1,
         32'h0000_6000, 4'b0010, 32'h0, 32'h0, 2'b10);

    // sb 0x3001 with grant held off for four cycles
    @(negedge clk);
    drive_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h1234_56AB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("sb.req%0d", i), 32'(dmem_req), 32'd1);
      chk($sformatf("sb.addr%0d", i), dmem_addr, 32'h0000_3000);
      chk($sformatf("sb.be%0d", i), 32'(dmem_be), 32'b0010);
      chk($sformatf("sb.wdata%0d", i), dmem_wdata, 32'hABAB_ABAB);
      chk($sformatf("sb.we%0d", i), 32'(dmem_we), 32'd1);
      chk($sformatf("sb.stall%0d", i), 32'(lsu_stall), 32'd1);
      if (i == 4) dmem_gnt = 1'b1;
    end
    @(negedge clk);
    chk("sb.req_drop", 32'(dmem_req), 32'd0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("sb.done", 32'(lsu_done), 32'd1);
    chk("sb.rdata", lsu_rdata, 32'd0);
    chk("sb.err", 32'(lsu_err), 32'd0);
    drop_op(); dmem_rvalid = 1'b0;

    // illegal size: fault one cycle after acceptance, no bus request
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    chk("ill.done", 32'(lsu_done), 32'd1);
    chk("ill.req", 32'(dmem_req), 32'd0);
    chk("ill.err", 32'(lsu_err), 32'd1);
    chk("ill.cause", 32'(lsu_err_cause), 32'd1);
    drop_op();

    // read and write together: fault
    @(negedge clk);
    drive_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    chk("rw.done", 32'(lsu_done), 32'd1);
    chk("rw.req", 32'(dmem_req), 32'd0);
    chk("rw.cause", 32'(lsu_err_cause), 32'd1);
    drop_op();

    // valid with neither read nor write is ignored
    @(negedge clk);
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'h0);
    #1 chk("nop.stall", 32'(lsu_stall), 32'd0);
    @(negedge clk);
    chk("nop.req", 32'(dmem_req), 32'd0);
    chk("nop.done", 32'(lsu_done), 32'd0);
    drop_op();

    // timeout: granted, never answered
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_8000, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("tmo.done_c%0d", i), 32'(lsu_done), 32'd0);
      chk($sformatf("tmo.stall_c%0d", i), 32'(lsu_stall), 32'd1);
      dmem_gnt = (i == 1);
    end
    @(negedge clk);
    chk("tmo.done", 32'(lsu_done), 32'd1);
    chk("tmo.err", 32'(lsu_err), 32'd1);
    chk("tmo.cause", 32'(lsu_err_cause), 32'd3);
    chk("tmo.req", 32'(dmem_req), 32'd0);
    chk("tmo.rdata", lsu_rdata, 32'd0);
    drop_op();
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("tmo.late_rvalid", 32'(lsu_done), 32'd0);
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("tmo.late_rvalid2", 32'(lsu_done), 32'd0);

    // lw 0x4002: misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_4002, 32'h0);
    @(negedge clk);
    chk("lwmis.done", 32'(lsu_done), 32'd1);
    chk("lwmis.req", 32'(dmem_req), 32'd0);
    chk("lwmis.cause", 32'(lsu_err_cause), 32'd1);
    drop_op();
`else
    xact("lwmis", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_4002, 32'h0, 32'hCAFE_BABE, 1'b0,
         32'h0000_4000, 4'b1111, 32'h0, 32'hCAFE_BABE, 2'b00);
`endif

    // a load that leaves nonzero data, then reset while waiting on the next one
    xact("lb2", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_7000, 32'h0, 32'h0000_0055, 1'b0,
         32'h0000_7000, 4'b0001, 32'h0, 32'h0000_0055, 2'b00);
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_9000, 32'h0);
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rstw.in_wait", 32'(lsu_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw.req", 32'(dmem_req), 32'd0);
    chk("rstw.stall", 32'(lsu_stall), 32'd0);
    chk("rstw.done", 32'(lsu_done), 32'd0);
    chk("rstw.rdata", lsu_rdata, 32'd0);
    drop_op();
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("rstw.ignored_done", 32'(lsu_done), 32'd0);
    chk("rstw.ignored_stall", 32'(lsu_stall), 32'd0);
    chk("rstw.ignored_req", 32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b0;

    // after reset the unit accepts a new op normally
    xact("post", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_A004, 32'h0, 32'h0BAD_F00D, 1'b0,
         32'h0000_A004, 4'b1111, 32'h0, 32'h0BAD_F00D, 2'b00);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sequencer between the pipeline's memory stage and the data-memory bus. Consumes the decoder's MemRead/MemWrite/NByteOp/Unsigned signals plus the ALU address. Runs one bus transaction per access through a req/gnt/rvalid handshake, generates byte enables and write-lane replication, and sign- or zero-extends load data. Stalls the pipeline until the access completes, and reports misalignment, bus errors and timeouts.

Parameters:
TIMEOUT_CYC, 1023, cycles spent in REQ+WAIT before abort; 0 = never time out.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
ex_valid  in  1  memory op present in the memory stage
ex_mem_read  in  1  load (decoder MemRead)
ex_mem_write  in  1  store (decoder MemWrite)
ex_nbyte  in  2  00 word, 01 byte, 10 half, 11 illegal
ex_unsigned  in  1  zero-extend load (lbu/lhu)
ex_addr  in  32  effective byte address
ex_wdata  in  32  store data (rs2)
lsu_stall  out  1  combinational pipeline stall
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  extended load result
lsu_err  out  1  access faulted; qualified by lsu_done
lsu_err_cause  out  2  00 none, 01 address/size fault, 10 bus error, 11 timeout
dmem_req  out  1  bus request
dmem_we  out  1  write
dmem_addr  out  32  word-aligned address, bits [1:0] = 00
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response valid (read data or write ack)
dmem_rdata  in  32  read data
dmem_err  in  1  response error, qualified by rvalid

Behaviour:
- Reset (async, any state): state = IDLE; all outputs 0, including dmem_req, which drops immediately. Any in-flight bus response arriving after reset is ignored.
- Valid op: ex_valid=1 and exactly one of read/write is set. A valid op with neither read nor write set is ignored. A valid op with both set, or with ex_nbyte=11, is an address/size fault.
- The pipeline holds ex_* stable from assertion until the lsu_done cycle.
- FSM states: IDLE, REQ, WAIT, RESP. All bus outputs and lsu_done/lsu_rdata/lsu_err are registered.
- IDLE, valid op: latch the op and compute be/addr/wdata.
  - Fault → RESP with cause 01; no bus access.
  - Otherwise → REQ.
- REQ: dmem_req=1, with addr/we/be/wdata stable.
  - dmem_gnt → WAIT; req is 0 next cycle.
  - rvalid seen in REQ is ignored.
- WAIT: dmem_req=0.
  - dmem_rvalid → RESP. Capture extended rdata for loads. dmem_err sets cause 10 and forces rdata to 0.
- RESP: lsu_done=1 for exactly one cycle, then → IDLE.
  - lsu_rdata holds its value until the next RESP; it is 0 for stores and errors.
  - No new op is accepted in RESP.
- Timeout: a counter clears on entry to REQ and increments in REQ/WAIT. Reaching TIMEOUT_CYC → RESP with cause 11, dropping dmem_req. A late rvalid arriving in IDLE is discarded.
- lsu_stall = (IDLE & ex_valid & (read|write)) | REQ | WAIT. It is low in RESP, so the pipeline advances on the lsu_done cycle.
- Latency: with gnt in the first REQ cycle and rvalid on the next cycle, lsu_done is asserted 3 cycles after acceptance. A fault reaches lsu_done 1 cycle after acceptance.
- Byte enables and write data:
  - byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = 0011 << (2*addr[1]); wdata = {2{wdata[15:0]}}.
  - word: be = 1111.
- Load data:
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend unless the latched unsigned flag is set, in which case zero-extend.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access is an address/size fault (cause 01); no bus access is made.
- Undefined: ignored low bits are masked (half ignores addr[0], word ignores addr[1:0]) and the access proceeds normally.
- ex_nbyte=11 faults in both builds.

Test Plan:
- lb from 0x1003, gnt immediate, rvalid next cycle with rdata 0x80FF_FF00 → dmem_addr 0x1000, be 1000, lsu_rdata 0xFFFF_FF80, lsu_done 3 cycles after accept.
- lhu from 0x2002, rdata 0xBEEF_1234 → be 1100, lsu_rdata 0x0000_BEEF, err=0.
- sb to 0x3001 with wdata 0x1234_56AB, gnt delayed 4 cycles → dmem_req held 5 cycles with stable outputs, be 0010, dmem_wdata 0xABAB_ABAB, we=1.
- lw from 0x4002:
  - with macro → no dmem_req, lsu_done+err with cause 01 one cycle after accept.
  - without macro → dmem_addr 0x4000, be 1111.
- TIMEOUT_CYC=8, gnt but no rvalid → done+err with cause 11 after 8 cycles; a late rvalid in IDLE causes no extra done.
- rst_n low while in WAIT → dmem_req/lsu_stall/lsu_done 0 immediately, state IDLE; a following rvalid is ignored.
